keccak_padder: RTL

KECCAK_PADDER -- requirements
Module: keccak_padder

---
 rtl/keccak_padder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/keccak_padder.sv
// Keccak/SHA3 message padder: packs 64-bit words into rate blocks and applies pad10*1.
// Define KECCAK_PAD_SHAKE_EN for the SHAKE domain byte (0x1F); otherwise SHA3 (0x06).
module keccak_padder #(
  parameter int WIDTH      = 64,
  parameter int RATE_LANES = 17
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          in_valid,
  input  logic                          in_last,
  input  logic [3:0]                    in_nbytes,
  output logic                          in_ready,
  output logic [0:4][0:4][WIDTH-1:0]    Dout,
  output logic                          Dout_valid,
  output logic                          Last_block,
  input  logic                          Dout_accept
);

  localparam int RB = RATE_LANES * WIDTH;
  localparam int AW = $clog2(RB);

`ifdef KECCAK_PAD_SHAKE_EN
  localparam logic [7:0] DOMAIN = 8'h1F;
`else
  localparam logic [7:0] DOMAIN = 8'h06;
`endif

  localparam logic [1:0] S_FILL   = 2'd0;
  localparam logic [1:0] S_PAD    = 2'd1;
  localparam logic [1:0] S_PADBLK = 2'd2;
  localparam logic [1:0] S_EMIT   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [4:0]    lane_q, lane_d;
  logic [3:0]    nb_q, nb_d;
  logic [RB-1:0] blk_q, blk_d;
  logic          last_q, last_d;
  logic          pend_q, pend_d;
  logic          ready_q, ready_d;

  logic [3:0]       nb_eff;
  logic             take;
  logic [WIDTH-1:0] mask;
  logic [7:0]       pad_pos;
  logic [AW-1:0]    pad_off;
  logic [AW-1:0]    lane_off;

  // Next-state logic: fill lanes, pad the final block, hold until accepted
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    nb_d     = nb_q;
    blk_d    = blk_q;
    last_d   = last_q;
    pend_d   = pend_q;
    nb_eff   = (in_nbytes > 4'd8) ? 4'd8 : in_nbytes;
    take     = in_valid & ready_q;
    pad_pos  = {lane_q, 3'b000} + {4'b0000, nb_q};
    pad_off  = AW'({pad_pos, 3'b000});
    lane_off = AW'({lane_q, 6'b000000});
    mask     = '0;
    for (int b = 0; b < WIDTH / 8; b++) begin
      if (!in_last || (4'(b) < nb_eff)) mask[8*b +: 8] = 8'hFF;
    end
    unique case (state_q)
      S_FILL: begin
        if (take) begin
          blk_d[lane_off +: WIDTH] = in_data & mask;
          if (in_last) begin
            nb_d = nb_eff;
            if (nb_eff == 4'd8 && lane_q == 5'(RATE_LANES - 1)) begin
              state_d = S_EMIT;
              last_d  = 1'b0;
              pend_d  = 1'b1;
            end else begin
              state_d = S_PAD;
            end
          end else if (lane_q == 5'(RATE_LANES - 1)) begin
            state_d = S_EMIT;
            last_d  = 1'b0;
            pend_d  = 1'b0;
          end else begin
            lane_d = lane_q + 5'd1;
          end
        end
      end
      S_PAD: begin
        blk_d[pad_off +: 8] = blk_q[pad_off +: 8] ^ DOMAIN;
        blk_d[RB-1 -: 8]    = blk_d[RB-1 -: 8] | 8'h80;
        state_d = S_EMIT;
        last_d  = 1'b1;
      end
      S_PADBLK: begin
        blk_d            = '0;
        blk_d[7:0]       = DOMAIN;
        blk_d[RB-1 -: 8] = 8'h80;
        pend_d  = 1'b0;
        state_d = S_EMIT;
        last_d  = 1'b1;
      end
      S_EMIT: begin
        if (Dout_accept) begin
          blk_d   = '0;
          lane_d  = '0;
          last_d  = 1'b0;
          state_d = pend_q ? S_PADBLK : S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
    ready_d = (state_d == S_FILL);
  end

  // State registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_FILL;
      lane_q  <= '0;
      nb_q    <= '0;
      blk_q   <= '0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      nb_q    <= nb_d;
      blk_q   <= blk_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
    end
  end

  // Map rate lanes into the 5x5 state; capacity lanes stay zero
  always_comb begin
    Dout = '0;
    for (int k = 0; k < RATE_LANES; k++) begin
      Dout[3'(k % 5)][3'(k / 5)] = blk_q[AW'(k * WIDTH) +: WIDTH];
    end
  end

  assign in_ready   = ready_q;
  assign Dout_valid = (state_q == S_EMIT);
  assign Last_block = last_q;

endmodule
